// File: rtl/mbtrain_sb_tx_arbiter_pkg.sv
// Shared MBTRAIN definitions: message width, sideband message codes and
// the sideband transmit arbiter state encoding.
package mbtrain_sb_tx_arbiter_pkg;

    localparam int unsigned MBTRAIN_MSG_W = 4;

    // Message codes shared with the substate tx/rx blocks
    localparam logic [MBTRAIN_MSG_W-1:0] START_REQ                  = 4'd1;
    localparam logic [MBTRAIN_MSG_W-1:0] START_RESP                 = 4'd2;
    localparam logic [MBTRAIN_MSG_W-1:0] ERROR_REQ                  = 4'd3;
    localparam logic [MBTRAIN_MSG_W-1:0] ERROR_RESP                 = 4'd4;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_REPAIR_REQ         = 4'd5;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_REPAIR_RESP        = 4'd6;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_SPEED_DEGRADE_REQ  = 4'd7;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_SPEED_DEGRADE_RESP = 4'd8;
    localparam logic [MBTRAIN_MSG_W-1:0] DONE_REQ                   = 4'd9;
    localparam logic [MBTRAIN_MSG_W-1:0] DONE_RESP                  = 4'd10;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_PHYRETRAIN_REQ     = 4'd11;
    localparam logic [MBTRAIN_MSG_W-1:0] EXIT_TO_PHYRETRAIN_RESP    = 4'd12;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StComplete
    } arb_state_e;

endpackage

// File: rtl/mbtrain_rr_pick.sv
// Combinational round-robin picker: first set bit of i_mask at or above
// i_ptr, wrapping to 0. Returns one-hot and binary index.
module mbtrain_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx
);

    logic             found;
    logic [IDX_W-1:0] j;

    // Scan upward from the pointer; the first hit wins
    always_comb begin
        found    = 1'b0;
        j        = '0;
        o_onehot = '0;
        o_idx    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = IDX_W'((int'(i_ptr) + k) % int'(NUM_REQ));
            if (!found && i_mask[j]) begin
                found       = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = j;
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/mbtrain_sb_tx_arbiter.sv
// MBTRAIN sideband transmit arbiter: grants one substate transmitter at a
// time, issues its message to the encoder, tracks the busy handshake and
// returns a per-requester done pulse. Responses beat requests.
module mbtrain_sb_tx_arbiter
    import mbtrain_sb_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MSG_W       = MBTRAIN_MSG_W,
    parameter int unsigned ACK_TIMEOUT = 64,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*MSG_W-1:0] i_req_msg,
    input  logic [NUM_REQ-1:0]       i_req_is_resp,
    input  logic                     i_sb_busy,
    output logic                     o_sb_valid,
    output logic [MSG_W-1:0]         o_sb_msg,
    output logic [IDX_W-1:0]         o_sb_src,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_timeout_err
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   rr_ptr_q, src_q;
    logic [MSG_W-1:0]   msg_q;
    logic [NUM_REQ-1:0] grant_q, done_q, served_q;
    logic [MSG_W-1:0]   last_msg_q [NUM_REQ];
    logic               sb_valid_q, timeout_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] eligible, resp_elig, keep;
    logic               resp_vld, all_vld, pick_vld;
    logic [NUM_REQ-1:0] resp_oh, all_oh, pick_oh;
    logic [IDX_W-1:0]   resp_idx, all_idx, pick_idx, rr_next;
    logic [MSG_W-1:0]   sel_msg;

    // keep[i]: request still holds the code last granted, so served may stay set
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            keep[i] = i_req_valid[i] & (i_req_msg[i*MSG_W +: MSG_W] == last_msg_q[i]);
        end
        eligible  = i_req_valid & ~served_q;
        resp_elig = eligible & i_req_is_resp;
    end

    mbtrain_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_resp (
        .i_mask   (resp_elig),
        .i_ptr    (rr_ptr_q),
        .o_valid  (resp_vld),
        .o_onehot (resp_oh),
        .o_idx    (resp_idx)
    );

    mbtrain_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_all (
        .i_mask   (eligible),
        .i_ptr    (rr_ptr_q),
        .o_valid  (all_vld),
        .o_onehot (all_oh),
        .o_idx    (all_idx)
    );

    // Response class wins whenever it has an eligible member
    always_comb begin
        pick_vld = resp_vld | all_vld;
        pick_oh  = resp_vld ? resp_oh  : all_oh;
        pick_idx = resp_vld ? resp_idx : all_idx;
        rr_next  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        sel_msg  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) sel_msg = i_req_msg[i*MSG_W +: MSG_W];
        end
    end

    // Arbiter FSM with registered outputs and served bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            msg_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            served_q   <= '0;
            sb_valid_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) last_msg_q[i] <= '0;
        end else begin
            sb_valid_q <= 1'b0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!keep[i]) served_q[i] <= 1'b0;
            end
            if (i_flush) begin
                state_q  <= StIdle;
                src_q    <= '0;
                msg_q    <= '0;
                grant_q  <= '0;
                cnt_q    <= '0;
                served_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (pick_vld) begin
                            state_q    <= StIssue;
                            src_q      <= pick_idx;
                            msg_q      <= sel_msg;
                            grant_q    <= pick_oh;
                            rr_ptr_q   <= rr_next;
                            sb_valid_q <= 1'b1;
                            for (int i = 0; i < int'(NUM_REQ); i++) begin
                                if (pick_oh[i]) last_msg_q[i] <= sel_msg;
                            end
                        end
                    end
                    StIssue: begin
                        state_q <= StWaitBusy;
                        cnt_q   <= '0;
                    end
                    StWaitBusy: begin
                        if (i_sb_busy) begin
                            state_q <= StWaitDone;
                        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                            // Abandon; served stays clear so the request is retried
                            state_q   <= StIdle;
                            timeout_q <= 1'b1;
                            grant_q   <= '0;
                            msg_q     <= '0;
                            src_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StWaitDone: begin
                        if (!i_sb_busy) state_q <= StComplete;
                    end
                    StComplete: begin
                        state_q <= StIdle;
                        done_q  <= grant_q;
                        grant_q <= '0;
                        msg_q   <= '0;
                        src_q   <= '0;
                        // A requester that already moved on must not be marked served
                        if (keep[src_q]) served_q[src_q] <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_sb_valid    = sb_valid_q;
    assign o_sb_msg      = msg_q;
    assign o_sb_src      = src_q;
    assign o_grant       = grant_q;
    assign o_done        = done_q;
    assign o_timeout_err = timeout_q;

endmodule

// File: tb/tb_mbtrain_sb_tx_arbiter.sv
// Self-checking bench for mbtrain_sb_tx_arbiter: cycle vector table for
// single-request and priority flows, hand sequences for the rest.
module tb_mbtrain_sb_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_msg;
    logic [3:0]  req_is_resp;
    logic        sb_busy;
    logic        sb_valid;
    logic [3:0]  sb_msg;
    logic [1:0]  sb_src;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    mbtrain_sb_tx_arbiter #(
        .NUM_REQ     (4),
        .MSG_W       (4),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .i_req_valid   (req_valid),
        .i_req_msg     (req_msg),
        .i_req_is_resp (req_is_resp),
        .i_sb_busy     (sb_busy),
        .o_sb_valid    (sb_valid),
        .o_sb_msg      (sb_msg),
        .o_sb_src      (sb_src),
        .o_grant       (grant),
        .o_done        (done),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] msg;
        logic [3:0]  resp;
        logic        busy;
        logic        e_sbv;
        logic [3:0]  e_msg;
        logic [1:0]  e_src;
        logic [3:0]  e_grant;
        logic [3:0]  e_done;
    } vec_t;

    vec_t vq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_msg(input int idx, input logic [3:0] m);
        req_msg[idx*4 +: 4] = m;
    endtask

    // Wait (bounded) for an issue strobe; reports whether one arrived
    task automatic wait_issue(input string tag, output bit ok);
        int n = 0;
        while (sb_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (sb_valid === 1'b1);
        chk({tag, ".issued"}, 32'(sb_valid), 32'd1);
    endtask

    // Expect an issue from idx with code m, then run a normal busy handshake
    task automatic serve(input int idx, input logic [3:0] m, input string tag);
        bit ok;
        wait_issue(tag, ok);
        if (!ok) return;
        chk({tag, ".src"}, 32'(sb_src), 32'(idx));
        chk({tag, ".msg"}, 32'(sb_msg), 32'(m));
        chk({tag, ".grant"}, 32'(grant), 32'(1 << idx));
        sb_busy = 1'b1;
        step();
        step();
        step();
        chk({tag, ".held_msg"}, 32'(sb_msg), 32'(m));
        sb_busy = 1'b0;
        step();
        chk({tag, ".no_early_done"}, 32'(done), 32'd0);
        step();
        chk({tag, ".done"}, 32'(done), 32'(1 << idx));
        chk({tag, ".grant_clr"}, 32'(grant), 32'd0);
        chk({tag, ".msg_clr"}, 32'(sb_msg), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int early;
        int order_idx [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int order_msg [8] = '{1, 1, 1, 1, 9, 9, 9, 9};

        rst_n       = 1'b0;
        flush       = 1'b0;
        req_valid   = '0;
        req_msg     = '0;
        req_is_resp = '0;
        sb_busy     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        chk("reset.sb_valid", 32'(sb_valid), 32'd0);
        chk("reset.sb_msg", 32'(sb_msg), 32'd0);
        chk("reset.sb_src", 32'(sb_src), 32'd0);
        chk("reset.grant", 32'(grant), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.timeout", 32'(timeout_err), 32'd0);

        // Single request: req0 START_REQ; 5 busy cycles; held request not resent
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b1, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b1, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b1, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b1, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b1, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b1, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd1, 2'd0, 4'b0001, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0001});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000});
        vq.push_back('{4'b0001, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000});
        vq.push_back('{4'b0000, 16'h0001, 4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000});
        // Priority: req1 START_REQ vs req2 START_RESP; busy already high in ISSUE
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b1, 4'd2, 2'd2, 4'b0100, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b1, 1'b0, 4'd2, 2'd2, 4'b0100, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b1, 1'b0, 4'd2, 2'd2, 4'b0100, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b0, 4'd2, 2'd2, 4'b0100, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0100});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b1, 4'd1, 2'd1, 4'b0010, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b0, 4'd1, 2'd1, 4'b0010, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b1, 1'b0, 4'd1, 2'd1, 4'b0010, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b0, 4'd1, 2'd1, 4'b0010, 4'b0000});
        vq.push_back('{4'b0110, 16'h0210, 4'b0100, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0010});
        vq.push_back('{4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000});

        for (int k = 0; k < vq.size(); k++) begin
            req_valid   = vq[k].valid;
            req_msg     = vq[k].msg;
            req_is_resp = vq[k].resp;
            sb_busy     = vq[k].busy;
            step();
            chk($sformatf("vec%0d.sb_valid", k), 32'(sb_valid), 32'(vq[k].e_sbv));
            chk($sformatf("vec%0d.sb_msg", k), 32'(sb_msg), 32'(vq[k].e_msg));
            chk($sformatf("vec%0d.sb_src", k), 32'(sb_src), 32'(vq[k].e_src));
            chk($sformatf("vec%0d.grant", k), 32'(grant), 32'(vq[k].e_grant));
            chk($sformatf("vec%0d.done", k), 32'(done), 32'(vq[k].e_done));
            chk($sformatf("vec%0d.timeout", k), 32'(timeout_err), 32'd0);
        end

        // Asynchronous reset in WAIT_DONE clears outputs without a clock edge
        req_valid = 4'b0100;
        set_msg(2, 4'd5);
        wait_issue("arst", ok);
        step();
        sb_busy = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.grant", 32'(grant), 32'd0);
        chk("arst.sb_msg", 32'(sb_msg), 32'd0);
        chk("arst.sb_src", 32'(sb_src), 32'd0);
        sb_busy   = 1'b0;
        req_valid = '0;
        req_msg   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Round-robin with per-requester code change after done (rr_ptr = 0)
        req_valid = 4'b1111;
        req_msg   = 16'h1111;
        for (int g = 0; g < 8; g++) begin
            serve(order_idx[g], 4'(order_msg[g]), $sformatf("rr%0d", g));
            set_msg(order_idx[g], 4'd9);
        end
        early = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (sb_valid) early++;
        end
        chk("rr.no_resend_held", 32'(early), 32'd0);
        req_valid = '0;
        step();

        // Timeout: busy never rises; retry follows
        req_valid = 4'b0001;
        set_msg(0, 4'd3);
        wait_issue("tmo", ok);
        early = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (timeout_err || (done != 4'b0000)) early++;
        end
        chk("tmo.no_early", 32'(early), 32'd0);
        step();
        chk("tmo.pulse", 32'(timeout_err), 32'd1);
        chk("tmo.grant_clr", 32'(grant), 32'd0);
        chk("tmo.no_done", 32'(done), 32'd0);
        serve(0, 4'd3, "tmo_retry");
        req_valid = '0;
        step();

        // Flush in WAIT_DONE with busy high
        req_valid = 4'b0010;
        set_msg(1, 4'd4);
        wait_issue("flush", ok);
        sb_busy = 1'b1;
        step();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.grant", 32'(grant), 32'd0);
        chk("flush.sb_msg", 32'(sb_msg), 32'd0);
        chk("flush.done", 32'(done), 32'd0);
        sb_busy = 1'b0;
        step();
        chk("flush.done_later", 32'(done), 32'd0);
        serve(1, 4'd4, "post_flush");

        // Flush coinciding with COMPLETE suppresses the done pulse
        set_msg(1, 4'd6);
        wait_issue("flush_cmp", ok);
        sb_busy = 1'b1;
        step();
        step();
        sb_busy = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_cmp.done", 32'(done), 32'd0);
        chk("flush_cmp.grant", 32'(grant), 32'd0);
        req_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbtrain_sb_tx_arbiter.md
Name: mbtrain_sb_tx_arbiter

Overview:
- Shares the single MBTRAIN sideband transmit path among NUM_REQ substate transmitters (linkspeed tx/rx, repair, speed-degrade, etc.).
- Each requester holds a level-valid 4-bit message code. The arbiter grants one requester at a time and forwards its message to the sideband encoder.
- It tracks the encoder busy handshake, then returns a per-requester done pulse that replaces the per-block busy-negedge detection.
- Responses take priority over requests so partner handshakes never stall behind new requests.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MSG_W, 4, message code width.
- ACK_TIMEOUT, 64, cycles to wait for i_sb_busy to rise after issue before abandoning the send.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous abort; LTSM leaving MBTRAIN
- i_req_valid  in  NUM_REQ  level request per requester
- i_req_msg  in  NUM_REQ*MSG_W  message per requester; requester i occupies bits [i*MSG_W +: MSG_W]
- i_req_is_resp  in  NUM_REQ  1 = message is a *_RESP (high-priority class)
- i_sb_busy  in  1  encoder busy; high while the message is serialised
- o_sb_valid  out  1  one-cycle issue strobe to the encoder
- o_sb_msg  out  MSG_W  message being issued or in flight
- o_sb_src  out  $clog2(NUM_REQ)  index of the granted requester
- o_grant  out  NUM_REQ  one-hot grant, held from issue to completion
- o_done  out  NUM_REQ  one-cycle pulse to the granted requester when its message completes
- o_timeout_err  out  1  one-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset: all outputs 0, FSM in IDLE, served[] = 0, last_msg[] = 0, rr_ptr = 0, timeout counter = 0.
- Eligibility: eligible[i] = i_req_valid[i] & ~served[i].
- Served tracking:
  - served[i] sets in COMPLETE for the granted i; last_msg[i] latches at grant.
  - served[i] clears on any cycle where i_req_valid[i] = 0 or i_req_msg[i] != last_msg[i]. An unchanged held request is never resent; a new code is.
- Arbitration, evaluated combinationally in IDLE:
  - If any eligible requester has i_req_is_resp set, pick from that class; otherwise pick from all eligible requesters.
  - Within a class, round-robin starting at rr_ptr, scanning upward and wrapping to 0.
  - On grant, rr_ptr <= granted index + 1, wrapping at NUM_REQ.
- FSM:
  - IDLE: if any requester is eligible, latch index and message; o_grant and o_sb_src are set next cycle; go to ISSUE.
  - ISSUE: o_sb_valid = 1 for exactly this cycle; o_sb_msg = latched message. Go to WAIT_BUSY and clear the counter.
  - WAIT_BUSY:
    - If i_sb_busy = 1, go to WAIT_DONE.
    - Otherwise increment the counter. When counter = ACK_TIMEOUT-1: pulse o_timeout_err, do not set served, clear the grant, go to IDLE. The request stays eligible, so it is retried.
  - WAIT_DONE: stay while i_sb_busy = 1. On i_sb_busy = 0, go to COMPLETE.
  - COMPLETE: o_done[src] = 1 for one cycle; served[src] <= 1; o_grant <= 0; go to IDLE.
- Latency:
  - Eligible request in IDLE to o_sb_valid: 1 cycle.
  - Busy falling to o_done: 2 cycles.
  - Back-to-back grants: the next ISSUE follows COMPLETE after one IDLE cycle.
- Held message: o_sb_msg holds the latched message from ISSUE through COMPLETE and ignores changes on i_req_msg while granted. It returns to 0 in IDLE.
- Requester drops valid while granted: the transfer still completes and o_done still pulses. The requester ignores the pulse; served clears next cycle because valid = 0.
- i_flush: highest priority. Next cycle state = IDLE, all outputs 0, served[] = 0, counter = 0. rr_ptr is preserved.
- Simultaneous flush and COMPLETE: flush wins; no o_done pulse.
- i_sb_busy already high in ISSUE (sticky encoder): accepted in WAIT_BUSY on the first cycle.
- Asynchronous reset mid-transfer: everything returns to reset values immediately; the encoder is expected to be reset by the same rst_n.

Decomposition:
- Shared MBTRAIN package holds:
  - MSG_W;
  - the message code constants (START_REQ=1 … EXIT_TO_PHYRETRAIN_RESP=12), shared with the substate tx/rx blocks;
  - the arbiter state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE).
- One sub-module, mbtrain_rr_pick: combinational round-robin priority picker (mask + rr_ptr → one-hot + index), instantiated twice: response class and all-eligible.

Test Plan:
- Single request: req0 valid, msg=START_REQ(1); busy high 2 cycles later for 5 cycles -> o_sb_valid pulses once with msg 1, src 0; o_done[0] pulses 2 cycles after busy falls; no reissue while valid stays high.
- Priority: req1 START_REQ (request) and req2 START_RESP(2) with is_resp asserted in the same cycle -> req2 issued first, req1 issued after o_done[2].
- Round-robin: req0..req3 all hold requests, each changing code after its done -> grant order 0,1,2,3,0; no requester starves.
- Message change while held: req0 stays valid; msg changes 1→9 (DONE_REQ) after done -> served clears and 9 is issued once.
- Timeout: busy never rises -> o_timeout_err pulses at cycle ACK_TIMEOUT after ISSUE; same request reissued; no o_done pulse.
- Flush during WAIT_DONE with busy high: i_flush=1 -> next cycle o_grant=0, o_sb_msg=0, no o_done; a subsequent request is served normally.
